// File: rtl/drive_sequencer_if.sv
// drive_sequencer_if: bundle between the pattern buffer / gate drivers and
// drive_sequencer.
//
// Signals:
//   pwm          PWM phase (1 = P side active, 0 = N side active)
//   p_drive      P-side pattern, applied while pwm = 1
//   n_drive      N-side pattern, applied while pwm = 0
//   tweak_delay  cycles from drive start to tweak start
//   tweak_en     per-bit tweak enables
//   p_gate       registered P gate drive
//   n_gate       registered N gate drive
//   tweak_out    registered tweak pulses
//   phase        registered sequencer state (0 DEAD, 1 WAIT, 2 TWEAK, 3 HOLD)
//   fault        sticky P/N overlap fault
//
// Handshake: there is no valid/ready pair. The producer holds the pattern
// inputs steady and the sequencer samples them only on the cycle it leaves
// DEAD; pwm is sampled on every rising edge.
//
// Modports: master = pattern source / observer, slave = drive_sequencer.

interface drive_sequencer_if #(
    parameter int buffer_width = 8
);
    logic                    pwm;
    logic [buffer_width-1:0] p_drive;
    logic [buffer_width-1:0] n_drive;
    logic [buffer_width-1:0] tweak_delay;
    logic [7:0]              tweak_en;
    logic [buffer_width-1:0] p_gate;
    logic [buffer_width-1:0] n_gate;
    logic [7:0]              tweak_out;
    logic [1:0]              phase;
    logic                    fault;

    modport master (
        output pwm, p_drive, n_drive, tweak_delay, tweak_en,
        input  p_gate, n_gate, tweak_out, phase, fault
    );

    modport slave (
        input  pwm, p_drive, n_drive, tweak_delay, tweak_en,
        output p_gate, n_gate, tweak_out, phase, fault
    );
endinterface

// File: rtl/drive_sequencer.sv
// drive_sequencer: output stage between the pattern buffer and the power
// drivers. Every PWM transition forces all gates off for dead_time cycles,
// then applies the pattern of the active phase and fires the tweak pulses
// tweak_delay cycles later for tweak_width cycles.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    drive_sequencer_if.slave (pattern inputs, gate/tweak outputs,
//          phase = current state, fault)
//
// Optional feature: define DRIVE_FAULT_EN to enable the sticky overlap fault
// that blanks all outputs once p_drive & n_drive overlap at a latch. When
// undefined, fault is tied to 0 and patterns are applied unchecked.

module drive_sequencer #(
    parameter int buffer_width = 8,
    parameter int dead_time    = 4,
    parameter int tweak_width  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    drive_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        DEAD  = 2'd0,
        WAIT  = 2'd1,
        TWEAK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [buffer_width-1:0] dead_load  = buffer_width'(dead_time - 1);
    localparam logic [buffer_width-1:0] tweak_load = buffer_width'(tweak_width - 1);
    localparam logic [buffer_width-1:0] one        = buffer_width'(1);

    state_t                  state;
    logic                    pwm_prev;
    logic [buffer_width-1:0] cnt;        // shared dead / delay / width counter
    logic [7:0]              tweak_en_q;
    logic [buffer_width-1:0] p_gate_q;
    logic [buffer_width-1:0] n_gate_q;
    logic [7:0]              tweak_q;
    logic                    pwm_edge;
    logic                    latch_now;
    logic                    block_drive;

    assign pwm_edge  = (bus.pwm != pwm_prev);
    // The pattern is captured on the last DEAD cycle unless an edge pre-empts it.
    assign latch_now = (state == DEAD) && !pwm_edge && (cnt == '0);

`ifdef DRIVE_FAULT_EN
    logic fault_q;

    // Blank the outputs both on the latch that detects the overlap and forever after.
    assign block_drive = fault_q | (|(bus.p_drive & bus.n_drive));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (latch_now && (|(bus.p_drive & bus.n_drive))) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.fault = fault_q;
`else
    assign block_drive = 1'b0;
    assign bus.fault   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DEAD;
            cnt        <= dead_load;
            pwm_prev   <= 1'b0;
            tweak_en_q <= '0;
            p_gate_q   <= '0;
            n_gate_q   <= '0;
            tweak_q    <= '0;
        end else begin
            pwm_prev <= bus.pwm;
            if (pwm_edge) begin
                // An edge wins over everything: restart dead time with all outputs off.
                state    <= DEAD;
                cnt      <= dead_load;
                p_gate_q <= '0;
                n_gate_q <= '0;
                tweak_q  <= '0;
            end else begin
                case (state)
                    DEAD: begin
                        if (cnt == '0) begin
                            p_gate_q   <= (bus.pwm && !block_drive) ? bus.p_drive : '0;
                            n_gate_q   <= (!bus.pwm && !block_drive) ? bus.n_drive : '0;
                            tweak_en_q <= block_drive ? 8'h00 : bus.tweak_en;
                            if (bus.tweak_delay == '0) begin
                                state   <= TWEAK;
                                tweak_q <= block_drive ? 8'h00 : bus.tweak_en;
                                cnt     <= tweak_load;
                            end else begin
                                state <= WAIT;
                                cnt   <= bus.tweak_delay - one;
                            end
                        end else begin
                            cnt <= cnt - one;
                        end
                    end
                    WAIT: begin
                        if (cnt == '0) begin
                            state   <= TWEAK;
                            tweak_q <= tweak_en_q;
                            cnt     <= tweak_load;
                        end else begin
                            cnt <= cnt - one;
                        end
                    end
                    TWEAK: begin
                        if (cnt == '0) begin
                            state   <= HOLD;
                            tweak_q <= '0;
                        end else begin
                            cnt <= cnt - one;
                        end
                    end
                    default: begin
                        // HOLD: gates stay as latched until the next edge.
                    end
                endcase
            end
        end
    end

    assign bus.p_gate    = p_gate_q;
    assign bus.n_gate    = n_gate_q;
    assign bus.tweak_out = tweak_q;
    assign bus.phase     = state;

endmodule
